// File: rtl/wb_pkg.sv
// Shared types for the Wishbone register-file responder.
// Bus widths, window default, engine states and the queued request record.
package wb_pkg;

    localparam int WB_DW = 16;
    localparam int WB_AW = 16;
    localparam logic [WB_AW-1:0] WB_BASE_ADDR = 16'h4020;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2
    } eng_state_t;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } wb_req_t;

    localparam int WB_REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/wb_req_fifo.sv
// Parametric synchronous FIFO with flush; holds bus requests in order.
module wb_req_fifo #(
    parameter int W          = 33,
    parameter int DEPTH_BITS = 2
) (
    input  logic                CLK_I,
    input  logic                RST_N_I,
    input  logic                push,
    input  logic [W-1:0]        din,
    input  logic                pop,
    input  logic                flush,
    output logic [W-1:0]        dout,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_BITS:0] count
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr;
    logic [DEPTH_BITS-1:0]   rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == (DEPTH_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK_I) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_BITS+1)'(1);
                2'b01:   count <= count - (DEPTH_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_slave_regfile.sv
// Pipelined Wishbone responder over a 16 x 16-bit register file.
// Requests queue in order and are answered after WAIT_STATES cycles each.
module wb_slave_regfile
    import wb_pkg::*;
#(
    parameter int WISHBONE_DATAWIDTH    = WB_DW,
    parameter int WISHBONE_ADDRESSWIDTH = WB_AW,
    parameter logic [WISHBONE_ADDRESSWIDTH-1:0] BASE_ADDR = WB_BASE_ADDR,
    parameter int WAIT_STATES           = 0,
    parameter int QDEPTH_BITS           = 2
) (
    input  logic                             CLK_I,
    input  logic                             RST_N_I,
    input  logic                             CYC_I,
    input  logic                             STB_I,
    input  logic                             WE_I,
    input  logic [WISHBONE_ADDRESSWIDTH-1:0] ADR_I,
    input  logic [WISHBONE_DATAWIDTH-1:0]    DAT_I,
    output logic [WISHBONE_DATAWIDTH-1:0]    DAT_O,
    output logic                             ACK_O,
    output logic                             ERR_O,
    output logic                             STALL_O,
    output logic                             reg_wr_pulse,
    output logic [3:0]                       reg_wr_index
);

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);
    localparam eng_state_t FIRST   = (WAIT_STATES == 0) ? EXEC : WAIT;

    eng_state_t                    state_q, state_d;
    logic [3:0]                    ws_q, ws_d;
    wb_req_t                       req_in, head;
    logic                          push, pop, full, empty, last, hit;
    logic [QDEPTH_BITS:0]          count;
    logic [3:0]                    idx;
    logic [WISHBONE_DATAWIDTH-1:0] regs [16];

    assign req_in  = '{we: WE_I, adr: ADR_I, dat: DAT_I};
    assign push    = CYC_I & STB_I & ~full;
    assign STALL_O = full;
    assign last    = (count == (QDEPTH_BITS+1)'(1));
    assign idx     = head.adr[3:0];
    assign hit     = head.adr[WISHBONE_ADDRESSWIDTH-1:4]
                     == BASE_ADDR[WISHBONE_ADDRESSWIDTH-1:4];

    wb_req_fifo #(
        .W          (WB_REQ_W),
        .DEPTH_BITS (QDEPTH_BITS)
    ) u_fifo (
        .CLK_I   (CLK_I),
        .RST_N_I (RST_N_I),
        .push    (push),
        .din     (req_in),
        .pop     (pop),
        .flush   (~CYC_I),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= IDLE;
            ws_q    <= '0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
        end
    end

    // Dropping CYC_I abandons everything queued, including a head in EXEC.
    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        pop     = 1'b0;
        if (!CYC_I) begin
            state_d = IDLE;
            ws_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (push || !empty) begin
                        state_d = FIRST;
                        ws_d    = WS_LOAD;
                    end
                end
                WAIT: begin
                    ws_d = ws_q - 4'd1;
                    if (ws_q <= 4'd1)
                        state_d = EXEC;
                end
                EXEC: begin
                    pop = 1'b1;
                    if (last && !push) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FIRST;
                        ws_d    = WS_LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            ACK_O        <= 1'b0;
            ERR_O        <= 1'b0;
            DAT_O        <= '0;
            reg_wr_pulse <= 1'b0;
            reg_wr_index <= '0;
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
        end else begin
            ACK_O        <= 1'b0;
            ERR_O        <= 1'b0;
            DAT_O        <= '0;
            reg_wr_pulse <= 1'b0;
            if (pop) begin
                if (!hit) begin
                    ERR_O <= 1'b1;
                end else if (head.we) begin
                    ACK_O        <= 1'b1;
                    regs[idx]    <= head.dat;
                    reg_wr_pulse <= 1'b1;
                    reg_wr_index <= idx;
                end else begin
                    ACK_O <= 1'b1;
                    DAT_O <= regs[idx];
                end
            end
        end
    end

endmodule
